// File: rtl/intbus_vram_arb.sv
// Internal-bus decode plus single-port VRAM arbiter. The CPU always wins, so video may stall but the CPU never does.
// CPU reads land in intbus_rddata two cycles after the strobe. Video data arrives the cycle after vid_ack.
module intbus_vram_arb #(
  parameter int RAM_AW    = 17,
  parameter int PERIPH_AW = 5,
  parameter int STALL_W   = 8
) (
  input  logic                 intbus_clk,
  input  logic                 extbus_reset,
  input  logic [RAM_AW:0]      intbus_addr,
  input  logic [7:0]           intbus_wrdata,
  input  logic                 intbus_strobe,
  input  logic                 intbus_write,
  output logic [7:0]           intbus_rddata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [7:0]           ram_wrdata,
  input  logic [7:0]           ram_rddata,
  output logic                 periph_strobe,
  output logic                 periph_write,
  output logic [PERIPH_AW-1:0] periph_addr,
  output logic [7:0]           periph_wrdata,
  input  logic [7:0]           periph_rddata,
  input  logic                 vid_req,
  input  logic [RAM_AW-1:0]    vid_addr,
  output logic                 vid_ack,
  output logic [7:0]           vid_rddata,
  output logic                 vid_rddata_valid,
  output logic [STALL_W-1:0]   vid_stall_cnt
);

  logic               cpu_ram;
  logic               cpu_per;
  logic               pend_cpu_ram_q, pend_cpu_ram_d;
  logic               pend_cpu_per_q, pend_cpu_per_d;
  logic [7:0]         intbus_rddata_q, intbus_rddata_d;
  logic               vid_rddata_valid_q, vid_rddata_valid_d;
  logic [STALL_W-1:0] vid_stall_cnt_q, vid_stall_cnt_d;

  // The top address bit splits VRAM from peripheral register space.
  assign cpu_ram = intbus_strobe & ~intbus_addr[RAM_AW];
  assign cpu_per = intbus_strobe &  intbus_addr[RAM_AW];

  always_comb begin
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = vid_addr;
    ram_wrdata = intbus_wrdata;
    vid_ack    = 1'b0;
    if (cpu_ram) begin
      ram_en   = 1'b1;
      ram_we   = intbus_write;
      ram_addr = intbus_addr[RAM_AW-1:0];
    end else if (vid_req) begin
      ram_en  = 1'b1;
      vid_ack = 1'b1;
    end
  end

  // Peripheral accesses leave the VRAM port free for video in the same cycle.
  assign periph_strobe = cpu_per;
  assign periph_write  = cpu_per & intbus_write;
  assign periph_addr   = intbus_addr[PERIPH_AW-1:0];
  assign periph_wrdata = intbus_wrdata;

  always_comb begin
    pend_cpu_ram_d     = cpu_ram & ~intbus_write;
    pend_cpu_per_d     = cpu_per & ~intbus_write;
    intbus_rddata_d    = intbus_rddata_q;
    vid_rddata_valid_d = vid_ack;
    vid_stall_cnt_d    = vid_stall_cnt_q;
    if (pend_cpu_ram_q) begin
      intbus_rddata_d = ram_rddata;
    end else if (pend_cpu_per_q) begin
      intbus_rddata_d = periph_rddata;
    end
    if (vid_req && cpu_ram && (vid_stall_cnt_q != {STALL_W{1'b1}})) begin
      vid_stall_cnt_d = vid_stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge intbus_clk or posedge extbus_reset) begin
    if (extbus_reset) begin
      pend_cpu_ram_q     <= 1'b0;
      pend_cpu_per_q     <= 1'b0;
      intbus_rddata_q    <= 8'h00;
      vid_rddata_valid_q <= 1'b0;
      vid_stall_cnt_q    <= '0;
    end else begin
      pend_cpu_ram_q     <= pend_cpu_ram_d;
      pend_cpu_per_q     <= pend_cpu_per_d;
      intbus_rddata_q    <= intbus_rddata_d;
      vid_rddata_valid_q <= vid_rddata_valid_d;
      vid_stall_cnt_q    <= vid_stall_cnt_d;
    end
  end

  assign intbus_rddata    = intbus_rddata_q;
  assign vid_rddata       = ram_rddata;
  assign vid_rddata_valid = vid_rddata_valid_q;
  assign vid_stall_cnt    = vid_stall_cnt_q;

endmodule

// File: tb/tb_intbus_vram_arb.sv
// Bench for intbus_vram_arb: behavioural VRAM/peripheral environment plus a transaction-level reference model.
module tb_intbus_vram_arb;
  localparam int RAM_AW = 17;
  localparam int PERIPH_AW = 5;
  localparam int STALL_W = 8;

  logic                 intbus_clk;
  logic                 extbus_reset;
  logic [RAM_AW:0]      intbus_addr;
  logic [7:0]           intbus_wrdata;
  logic                 intbus_strobe;
  logic                 intbus_write;
  logic [7:0]           intbus_rddata;
  logic                 ram_en;
  logic                 ram_we;
  logic [RAM_AW-1:0]    ram_addr;
  logic [7:0]           ram_wrdata;
  logic [7:0]           ram_rddata;
  logic                 periph_strobe;
  logic                 periph_write;
  logic [PERIPH_AW-1:0] periph_addr;
  logic [7:0]           periph_wrdata;
  logic [7:0]           periph_rddata;
  logic                 vid_req;
  logic [RAM_AW-1:0]    vid_addr;
  logic                 vid_ack;
  logic [7:0]           vid_rddata;
  logic                 vid_rddata_valid;
  logic [STALL_W-1:0]   vid_stall_cnt;

  intbus_vram_arb #(.RAM_AW(RAM_AW), .PERIPH_AW(PERIPH_AW), .STALL_W(STALL_W)) dut (
    .intbus_clk(intbus_clk), .extbus_reset(extbus_reset),
    .intbus_addr(intbus_addr), .intbus_wrdata(intbus_wrdata),
    .intbus_strobe(intbus_strobe), .intbus_write(intbus_write),
    .intbus_rddata(intbus_rddata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata),
    .periph_strobe(periph_strobe), .periph_write(periph_write),
    .periph_addr(periph_addr), .periph_wrdata(periph_wrdata),
    .periph_rddata(periph_rddata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rddata(vid_rddata), .vid_rddata_valid(vid_rddata_valid),
    .vid_stall_cnt(vid_stall_cnt)
  );

  initial intbus_clk = 1'b0;
  always #5 intbus_clk = ~intbus_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Power-up contents of the memories; unwritten locations read as this hash.
  function automatic logic [7:0] seed_byte(input int a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1 + 32'h1234_5678;
    return h[23:16];
  endfunction

  // Environment: synchronous VRAM and peripheral register file, one cycle read latency.
  logic [7:0] vram [int];
  logic [7:0] pregs [int];
  always @(posedge intbus_clk) begin
    if (ram_en) begin
      ram_rddata <= vram.exists(int'(ram_addr)) ? vram[int'(ram_addr)] : seed_byte(int'(ram_addr));
      if (ram_we) vram[int'(ram_addr)] = ram_wrdata;
    end
    if (periph_strobe) begin
      periph_rddata <= pregs.exists(int'(periph_addr)) ? pregs[int'(periph_addr)] : seed_byte(int'(periph_addr) + 1000);
      if (periph_write) pregs[int'(periph_addr)] = periph_wrdata;
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [int];
  logic [7:0] ref_per [int];
  logic [7:0] exp_rddata, exp_vdata, pend_val;
  logic       exp_vvalid, pend_v;
  int         exp_stall;
  logic       exp_ack, exp_ram_en, exp_ram_we, exp_per;
  logic [16:0] exp_ram_addr;

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_byte(a);
  endfunction

  function automatic logic [7:0] ref_prd(input int a);
    return ref_per.exists(a) ? ref_per[a] : seed_byte(a + 1000);
  endfunction

  task automatic model_reset();
    exp_rddata = 8'h00;
    exp_vvalid = 1'b0;
    exp_stall  = 0;
    pend_v     = 1'b0;
  endtask

  // Apply one cycle's inputs (called just after a falling edge) and derive the expected routing.
  task automatic drive(input logic s, input logic w, input logic [17:0] a, input logic [7:0] d,
                       input logic vr, input logic [16:0] va);
    logic cr;
    intbus_strobe = s;
    intbus_write  = w;
    intbus_addr   = a;
    intbus_wrdata = d;
    vid_req       = vr;
    vid_addr      = va;
    cr            = s && !a[17];
    exp_ack       = vr && !cr;
    exp_ram_en    = cr || vr;
    exp_ram_we    = cr && w;
    exp_ram_addr  = cr ? a[16:0] : va;
    exp_per       = s && a[17];
    #1;
  endtask

  // Advance one clock; the model retires the transaction presented this cycle.
  task automatic tick();
    @(posedge intbus_clk);
    if (extbus_reset) begin
      model_reset();
    end else begin
      logic cr, cp;
      cr = intbus_strobe && !intbus_addr[17];
      cp = intbus_strobe && intbus_addr[17];
      if (pend_v) exp_rddata = pend_val;
      pend_v     = (cr || cp) && !intbus_write;
      pend_val   = cr ? ref_rd(int'(intbus_addr[16:0])) : ref_prd(int'(intbus_addr[4:0]));
      exp_vvalid = vid_req && !cr;
      exp_vdata  = ref_rd(int'(vid_addr));
      if (cr && intbus_write) ref_mem[int'(intbus_addr[16:0])] = intbus_wrdata;
      if (cp && intbus_write) ref_per[int'(intbus_addr[4:0])] = intbus_wrdata;
      if (vid_req && cr && exp_stall < 255) exp_stall++;
    end
    @(negedge intbus_clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    extbus_reset = 1'b1;
    model_reset();
    @(negedge intbus_clk);
    @(negedge intbus_clk);
    extbus_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (intbus_rddata !== 8'h00) begin n_fail++; $display("FAIL reset_rddata: got %h want 00", intbus_rddata); end
    n_cmp++; if (vid_rddata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vvalid: got %b want 0", vid_rddata_valid); end
    n_cmp++; if (vid_stall_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_stall: got %h want 00", vid_stall_cnt); end
    n_cmp++; if ({ram_en, ram_we, periph_strobe, vid_ack} !== 4'b0000) begin n_fail++; $display("FAIL reset_comb: got %b want 0000", {ram_en, ram_we, periph_strobe, vid_ack}); end
  endtask

  task automatic test_cpu_ram_rw();
    drive(1, 1, 18'h01234, 8'h5A, 0, 0);
    n_cmp++; if ({ram_en, ram_we} !== 2'b11) begin n_fail++; $display("FAIL wr_en_we: got %b want 11", {ram_en, ram_we}); end
    n_cmp++; if (ram_addr !== 17'h01234 || ram_wrdata !== 8'h5A) begin n_fail++; $display("FAIL wr_addr_data: got %h/%h want 01234/5a", ram_addr, ram_wrdata); end
    tick();
    drive(1, 0, 18'h01234, 8'h00, 0, 0);
    n_cmp++; if ({ram_en, ram_we} !== 2'b10) begin n_fail++; $display("FAIL rd_en_we: got %b want 10", {ram_en, ram_we}); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (intbus_rddata !== 8'h00) begin n_fail++; $display("FAIL rd_early: got %h want 00", intbus_rddata); end
    tick();
    n_cmp++; if (intbus_rddata !== 8'h5A) begin n_fail++; $display("FAIL rd_lat2: got %h want 5a", intbus_rddata); end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (intbus_rddata !== 8'h5A) begin n_fail++; $display("FAIL rd_hold: got %h want 5a", intbus_rddata); end
  endtask

  task automatic test_vid_fetch();
    drive(1, 1, 18'h00010, 8'hC3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 17'h00010);
    n_cmp++; if ({vid_ack, ram_en, ram_we} !== 3'b110) begin n_fail++; $display("FAIL vid_grant: got %b want 110", {vid_ack, ram_en, ram_we}); end
    n_cmp++; if (ram_addr !== 17'h00010) begin n_fail++; $display("FAIL vid_addr: got %h want 00010", ram_addr); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (vid_rddata_valid !== 1'b1 || vid_rddata !== 8'hC3) begin n_fail++; $display("FAIL vid_data: got %b/%h want 1/c3", vid_rddata_valid, vid_rddata); end
    tick();
    n_cmp++; if (vid_rddata_valid !== 1'b0) begin n_fail++; $display("FAIL vid_valid_drop: got %b want 0", vid_rddata_valid); end
  endtask

  task automatic test_vid_stall();
    logic [17:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = {1'b0, 13'h0100, 4'($urandom)};
      drive(1, 0, a, 8'h00, 1, 17'h00020);
      n_cmp++; if (vid_ack !== 1'b0 || ram_addr !== a[16:0]) begin n_fail++; $display("FAIL stall_deny%0d: got ack=%b addr=%h want 0/%h", i, vid_ack, ram_addr, a[16:0]); end
      tick();
    end
    drive(0, 0, 0, 0, 1, 17'h00020);
    n_cmp++; if (vid_ack !== 1'b1) begin n_fail++; $display("FAIL stall_ack4: got %b want 1", vid_ack); end
    n_cmp++; if (vid_stall_cnt !== 8'd3) begin n_fail++; $display("FAIL stall_cnt3: got %0d want 3", vid_stall_cnt); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_periph_read();
    drive(1, 1, 18'h20007, 8'h99, 0, 0);
    n_cmp++; if ({periph_strobe, periph_write, ram_en} !== 3'b110) begin n_fail++; $display("FAIL per_wr: got %b want 110", {periph_strobe, periph_write, ram_en}); end
    tick();
    drive(1, 0, 18'h20007, 8'h00, 1, 17'h00055);
    n_cmp++; if ({periph_strobe, periph_write} !== 2'b10 || periph_addr !== 5'd7) begin n_fail++; $display("FAIL per_rd: got %b addr=%0d want 10/7", {periph_strobe, periph_write}, periph_addr); end
    n_cmp++; if ({ram_en, vid_ack} !== 2'b11 || ram_addr !== 17'h00055) begin n_fail++; $display("FAIL per_vid: got %b addr=%h want 11/00055", {ram_en, vid_ack}, ram_addr); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL per_idle_en: got %b want 0", ram_en); end
    tick();
    n_cmp++; if (intbus_rddata !== 8'h99) begin n_fail++; $display("FAIL per_rddata: got %h want 99", intbus_rddata); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va, vb, vc, prev;
    va = ref_rd(32'h00345);
    vb = ref_prd(12);
    vc = ref_rd(32'h1FFFF);
    prev = exp_rddata;
    drive(1, 0, 18'h00345, 0, 0, 0);
    tick();
    drive(1, 0, 18'h2000C, 0, 0, 0);
    n_cmp++; if (intbus_rddata !== prev) begin n_fail++; $display("FAIL b2b_c1: got %h want %h", intbus_rddata, prev); end
    tick();
    drive(1, 0, 18'h1FFFF, 0, 0, 0);
    n_cmp++; if (intbus_rddata !== va) begin n_fail++; $display("FAIL b2b_a: got %h want %h", intbus_rddata, va); end
    tick();
    drive(1, 1, 18'h00345, ~va, 0, 0);
    n_cmp++; if (intbus_rddata !== vb) begin n_fail++; $display("FAIL b2b_b: got %h want %h", intbus_rddata, vb); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (intbus_rddata !== vc) begin n_fail++; $display("FAIL b2b_c: got %h want %h", intbus_rddata, vc); end
    tick();
    tick();
    n_cmp++; if (intbus_rddata !== vc) begin n_fail++; $display("FAIL b2b_wr_hold: got %h want %h", intbus_rddata, vc); end
  endtask

  task automatic test_write_collision();
    drive(1, 1, 18'h00777, 8'hE7, 1, 17'h00777);
    n_cmp++; if ({vid_ack, ram_we} !== 2'b01) begin n_fail++; $display("FAIL coll_cpu: got %b want 01", {vid_ack, ram_we}); end
    tick();
    drive(0, 0, 0, 0, 1, 17'h00777);
    n_cmp++; if (vid_ack !== 1'b1) begin n_fail++; $display("FAIL coll_ack: got %b want 1", vid_ack); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (vid_rddata_valid !== 1'b1 || vid_rddata !== 8'hE7) begin n_fail++; $display("FAIL coll_data: got %b/%h want 1/e7", vid_rddata_valid, vid_rddata); end
    tick();
  endtask

  task automatic test_random();
    logic s, w, vr;
    logic [17:0] a;
    logic [16:0] va;
    vr = 1'b0;
    va = '0;
    for (int i = 0; i < 400; i++) begin
      n_cmp++; if (intbus_rddata !== exp_rddata) begin n_fail++; $display("FAIL rnd_rddata@%0d: got %h want %h", i, intbus_rddata, exp_rddata); end
      n_cmp++; if (vid_rddata_valid !== exp_vvalid) begin n_fail++; $display("FAIL rnd_vvalid@%0d: got %b want %b", i, vid_rddata_valid, exp_vvalid); end
      if (exp_vvalid) begin
        n_cmp++; if (vid_rddata !== exp_vdata) begin n_fail++; $display("FAIL rnd_vdata@%0d: got %h want %h", i, vid_rddata, exp_vdata); end
      end
      n_cmp++; if (int'(vid_stall_cnt) !== exp_stall) begin n_fail++; $display("FAIL rnd_stall@%0d: got %0d want %0d", i, vid_stall_cnt, exp_stall); end
      s = ($urandom_range(0, 9) < 6);
      w = 1'($urandom);
      a = {1'($urandom), 13'h0000, 4'($urandom)};
      if (!vr || exp_ack) begin
        vr = 1'($urandom);
        va = {13'h0000, 4'($urandom)};
      end
      drive(s, w, a, 8'($urandom), vr, va);
      n_cmp++; if ({ram_en, vid_ack, periph_strobe} !== {exp_ram_en, exp_ack, exp_per}) begin n_fail++; $display("FAIL rnd_route@%0d: got %b want %b", i, {ram_en, vid_ack, periph_strobe}, {exp_ram_en, exp_ack, exp_per}); end
      if (exp_ram_en) begin
        n_cmp++; if (ram_we !== exp_ram_we || ram_addr !== exp_ram_addr) begin n_fail++; $display("FAIL rnd_ram@%0d: got we=%b addr=%h want %b/%h", i, ram_we, ram_addr, exp_ram_we, exp_ram_addr); end
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  task automatic test_stall_saturate();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, {1'b0, 17'($urandom)}, 0, 1, 17'h00001);
      tick();
    end
    n_cmp++; if (vid_stall_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_256: got %h want ff", vid_stall_cnt); end
    for (int i = 0; i < 44; i++) begin
      drive(1, 0, {1'b0, 17'($urandom)}, 0, 1, 17'h00001);
      tick();
    end
    n_cmp++; if (vid_stall_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_300: got %h want ff", vid_stall_cnt); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive(1, 1, 18'h00100, 8'h3C, 0, 0);
    tick();
    drive(1, 0, 18'h00100, 0, 0, 0);
    tick();
    drive(1, 1, 18'h20003, 8'h6E, 0, 0);
    tick();
    n_cmp++; if (intbus_rddata !== 8'h3C) begin n_fail++; $display("FAIL mid_pre: got %h want 3c", intbus_rddata); end
    drive(1, 0, 18'h20003, 0, 1, 17'h00200);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (vid_rddata_valid !== 1'b1) begin n_fail++; $display("FAIL mid_vvalid_pre: got %b want 1", vid_rddata_valid); end
    extbus_reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (intbus_rddata !== 8'h00 || vid_rddata_valid !== 1'b0) begin n_fail++; $display("FAIL mid_clear: got %h/%b want 00/0", intbus_rddata, vid_rddata_valid); end
    tick();
    extbus_reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (intbus_rddata !== 8'h00) begin n_fail++; $display("FAIL mid_no_update: got %h want 00", intbus_rddata); end
  endtask

  initial begin
    extbus_reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge intbus_clk);
    test_reset();
    test_cpu_ram_rw();
    test_vid_fetch();
    test_vid_stall();
    test_periph_read();
    test_back_to_back();
    test_write_collision();
    test_random();
    test_stall_saturate();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
